// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and reset default for the instruction fetch path.
package fetch_pkg;
    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 11'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs; flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: nothing is read unless count says it was written.
    always_ff @(posedge clk) begin
        if (push && !flush)
            r_mem[r_wr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + PTR_W'(1);
            if (pop)  r_rd <= r_rd + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd];
    assign count = r_count;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks pc through external imem into a small queue feeding decode.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               busy
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int Q_W   = INSTR_W + ADDR_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  w_count;
    logic [Q_W-1:0]    w_head;
    logic              w_valid;
    logic              w_pop;
    logic              w_full;
    logic              w_fetch;

    assign w_valid = (w_count != '0);
    assign w_full  = (w_count == CNT_W'(DEPTH));
    assign w_pop   = w_valid && inst_ready;
    // A pop frees a slot in the same edge, so a full queue can still accept a fetch.
    assign w_fetch = (r_state == ST_FETCH) && fetch_en && !redirect_valid && (!w_full || w_pop);

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(Q_W)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (w_fetch),
        .pop   (w_pop),
        .wdata ({imem_data, r_pc}),
        .rdata (w_head),
        .count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (fetch_en) w_state_nxt = ST_FETCH;
            ST_FETCH:
                if (!fetch_en)
                    w_state_nxt = ST_IDLE;
                else if (!redirect_valid && !w_pop &&
                         (w_full || (w_fetch && w_count == CNT_W'(DEPTH - 1))))
                    w_state_nxt = ST_STALL;
            ST_STALL:
                if (!fetch_en)
                    w_state_nxt = ST_IDLE;
                else if (w_pop || redirect_valid)
                    w_state_nxt = ST_FETCH;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)
                r_pc <= redirect_pc;
            else if (w_fetch)
                r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign imem_addr  = r_pc;
    assign busy       = (r_state != ST_IDLE);
    assign inst_valid = w_valid;
    assign inst_data  = w_valid ? w_head[ADDR_W +: INSTR_W] : '0;
    assign inst_pc    = w_valid ? w_head[ADDR_W-1:0] : '0;
endmodule
